tach_rpm_scheduler: RTL

//  Gates wheel-tachometer edge counts over a fixed window of 10 kHz clk_en ticks for N_CH channels.

---
 rtl/tach_rpm_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tach_rpm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tach_rpm_scheduler
// Purpose  : Counts wheel-tachometer edges over a fixed window of clk_en
//            ticks on N_CH channels. One shared shift-add multiplier then
//            scales each channel's count into RPM.
//            rpm = (count * RPM_MULT) >> 8, saturated to RPM_W bits.
// Ports    : clk_in         - system clock
//            reset_in       - asynchronous reset, active-high
//            clk_en         - single-cycle gate tick
//            enable_in      - 1 = measure, 0 = counters and window held at 0
//            tach_pulse_in  - raw asynchronous tachometer pulses, one per channel
//            rpm_out        - channel k at [k*RPM_W +: RPM_W]
//            rpm_valid_out  - one-cycle strobe per channel when rpm_out updates
//            busy_out       - conversion batch in progress
//            overrun_out    - sticky: a window ended while a batch was running
// Revision : 1.0 - initial release
// ============================================================================
module tach_rpm_scheduler #(
  parameter int N_CH         = 2,
  parameter int WINDOW_TICKS = 500,
  parameter int CNT_W        = 10,
  parameter int RPM_MULT     = 853,
  parameter int MULT_W       = 12,
  parameter int RPM_W        = 10
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    clk_en,
  input  logic                    enable_in,
  input  logic [N_CH-1:0]         tach_pulse_in,
  output logic [N_CH*RPM_W-1:0]   rpm_out,
  output logic [N_CH-1:0]         rpm_valid_out,
  output logic                    busy_out,
  output logic                    overrun_out
);

  localparam int ACC_W = CNT_W + MULT_W;
  localparam int WIN_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BIT_W = $clog2(CNT_W + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_TICKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [MULT_W-1:0] MULT_K   = MULT_W'(RPM_MULT);
  localparam logic [ACC_W-1:0]  RPM_SAT  = ACC_W'({RPM_W{1'b1}});
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    MULT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers, edge detection, window counter and pulse counters
  // --------------------------------------------------------------------------
  logic [N_CH-1:0]  sync1, sync2, sync3;
  logic [N_CH-1:0]  rise;
  logic [WIN_W-1:0] win_cnt;
  logic             window_end;
  logic [CNT_W-1:0] cnt [N_CH];

  // sync3 is the previous synchronised level, so a rising edge reaches the
  // counter on the third edge after the raw pulse is first sampled.
  assign rise       = sync2 & ~sync3;
  assign window_end = enable_in && clk_en && (win_cnt == WIN_LAST);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      win_cnt <= '0;
      for (int k = 0; k < N_CH; k++) cnt[k] <= '0;
    end else begin
      sync1 <= tach_pulse_in;
      sync2 <= sync1;
      sync3 <= sync2;

      if (!enable_in)      win_cnt <= '0;
      else if (window_end) win_cnt <= '0;
      else if (clk_en)     win_cnt <= win_cnt + 1'b1;

      for (int k = 0; k < N_CH; k++) begin
        if (!enable_in)
          cnt[k] <= '0;
        else if (window_end)
          // An edge coinciding with the window boundary belongs to the new window.
          cnt[k] <= rise[k] ? CNT_W'(1) : '0;
        else if (rise[k] && (cnt[k] != CNT_MAX))
          cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Conversion sequencer with shared shift-add multiplier
  // --------------------------------------------------------------------------
  state_t           state;
  logic [CH_W-1:0]  ch;
  logic [BIT_W-1:0] bit_idx;
  logic [CNT_W-1:0] snap [N_CH];
  logic [CNT_W-1:0] mcand;   // count, consumed LSB first
  logic [ACC_W-1:0] mplier;  // scale factor, shifted left each step
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] scaled;
  logic [RPM_W-1:0] rpm_sat;

  assign scaled   = acc >> 8;
  assign rpm_sat  = (scaled > RPM_SAT) ? '1 : scaled[RPM_W-1:0];
  assign busy_out = (state != IDLE);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state         <= IDLE;
      ch            <= '0;
      bit_idx       <= '0;
      mcand         <= '0;
      mplier        <= '0;
      acc           <= '0;
      rpm_out       <= '0;
      rpm_valid_out <= '0;
      overrun_out   <= 1'b0;
      for (int k = 0; k < N_CH; k++) snap[k] <= '0;
    end else begin
      rpm_valid_out <= '0;

      // A window closing mid-batch is dropped; the running batch is untouched.
      if (window_end) begin
        if (state == IDLE) begin
          for (int k = 0; k < N_CH; k++) snap[k] <= cnt[k];
          ch    <= '0;
          state <= LOAD;
        end else begin
          overrun_out <= 1'b1;
        end
      end

      case (state)
        LOAD: begin
          mcand   <= snap[ch];
          mplier  <= ACC_W'(MULT_K);
          acc     <= '0;
          bit_idx <= '0;
          state   <= MULT;
        end
        MULT: begin
          if (mcand[0]) acc <= acc + mplier;
          mcand   <= mcand >> 1;
          mplier  <= mplier << 1;
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == BIT_LAST) state <= WRITE;
        end
        WRITE: begin
          rpm_out[ch*RPM_W +: RPM_W] <= rpm_sat;
          rpm_valid_out[ch]          <= 1'b1;
          if (ch == CH_LAST) begin
            state <= IDLE;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
